// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM-stage data-RAM controller (byte/half/word store lanes, load extension, ack timeout).
// Latency: request registered one cycle after the access is seen; the result is registered on ack and shown in DONE (min 2 stall cycles).
// Backpressure: o_StallM holds the pipeline from access detection until ack or timeout, then drops for exactly one DONE cycle.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word accesses without issuing a request (adds o_MisalignM).
module memory_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  input  logic                     i_MemWriteM,
  input  logic [1:0]               i_MemtoRegM,
  input  logic [2:0]               i_MemDataSelM,
  input  logic [1:0]               i_RAM_selM,
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  output logic [3:0]               o_mem_be,
  output logic [1:0]               o_mem_bank,
  input  logic                     i_mem_ack,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
  output logic [DATA_WIDTH-1:0]    o_ReadDataM,
  output logic                     o_StallM,
`ifdef MISALIGN_TRAP_EN
  output logic                     o_MisalignM,
`endif
  output logic                     o_BusErrM
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Everything presented on the RAM port for one access.
  typedef struct packed {
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [3:0]               be;
    logic [1:0]               bank;
  } req_t;

  state_t                  state, state_n;
  req_t                    req_q, req_c;
  logic                    req_vld;
  logic [CW-1:0]           cnt;
  logic [2:0]              sel_q;
  logic [1:0]              off_q;
  logic                    acc;
  logic                    is_byte, is_half;
  logic [1:0]              a;
  logic                    issue, finish, timeout, zero_rd, stall_c;
  logic [7:0]              byte_lane;
  logic [15:0]             half_lane;
  logic [DATA_WIDTH-1:0]   load_fmt;

  assign acc     = i_MemWriteM | (i_MemtoRegM == 2'b01);
  assign a       = i_ALUOutM[1:0];
  assign is_byte = (i_MemDataSelM == 3'b011) | (i_MemDataSelM == 3'b100);
  assign is_half = (i_MemDataSelM == 3'b001) | (i_MemDataSelM == 3'b010);

`ifdef MISALIGN_TRAP_EN
  logic misalign, trap;
  assign misalign = (is_half & a[0]) | (~is_byte & ~is_half & (a != 2'b00));
`endif

  // Build the RAM request (lanes, enables, aligned address) from the EX/MEM inputs.
  always_comb begin
    req_c      = '0;
    req_c.we   = i_MemWriteM;
    req_c.addr = {i_ALUOutM[ADDRESS_WIDTH-1:2], 2'b00};
    req_c.bank = i_RAM_selM;
    if (is_byte) begin
      req_c.be = 4'b0001 << a;
      if (i_MemWriteM) req_c.wdata = {4{i_WriteDataM[7:0]}};
    end else if (is_half) begin
      req_c.be = a[1] ? 4'b1100 : 4'b0011;
      if (i_MemWriteM) req_c.wdata = {2{i_WriteDataM[15:0]}};
    end else begin
      req_c.be = 4'b1111;
      if (i_MemWriteM) req_c.wdata = i_WriteDataM;
    end
  end

  // Extract the addressed lane from the returned word and extend it per the latched size/sign.
  always_comb begin
    byte_lane = i_mem_rdata[{off_q, 3'b000} +: 8];
    half_lane = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (sel_q)
      3'b001:  load_fmt = {{16{half_lane[15]}}, half_lane};
      3'b010:  load_fmt = {16'h0000, half_lane};
      3'b011:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_fmt = {24'h000000, byte_lane};
      default: load_fmt = i_mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and stall decode; ack in the timeout cycle takes priority over the error.
  always_comb begin
    state_n = state;
    stall_c = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    zero_rd = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (acc) begin
          stall_c = 1'b1;
`ifdef MISALIGN_TRAP_EN
          if (misalign) begin
            trap    = 1'b1;
            zero_rd = 1'b1;
            state_n = DONE;
          end else begin
            issue   = 1'b1;
            state_n = BUSY;
          end
`else
          issue   = 1'b1;
          state_n = BUSY;
`endif
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (i_mem_ack) begin
          finish  = 1'b1;
          state_n = DONE;
        end else if (cnt == LAST_CNT) begin
          timeout = 1'b1;
          zero_rd = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request/response datapath: latch on issue, clear on completion, count BUSY cycles.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      req_q       <= '0;
      req_vld     <= 1'b0;
      cnt         <= '0;
      sel_q       <= 3'b000;
      off_q       <= 2'b00;
      o_ReadDataM <= '0;
      o_BusErrM   <= 1'b0;
    end else begin
      o_BusErrM <= timeout;
      if (issue) begin
        req_q   <= req_c;
        req_vld <= 1'b1;
        cnt     <= '0;
        sel_q   <= i_MemDataSelM;
        off_q   <= a;
      end else if (finish || timeout) begin
        req_q   <= '0;
        req_vld <= 1'b0;
        cnt     <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (finish)       o_ReadDataM <= req_q.we ? '0 : load_fmt;
      else if (zero_rd) o_ReadDataM <= '0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle misalignment flag, visible in the DONE cycle.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) o_MisalignM <= 1'b0;
    else        o_MisalignM <= trap;
  end
`endif

  assign o_mem_req   = req_vld;
  assign o_mem_we    = req_q.we;
  assign o_mem_addr  = req_q.addr;
  assign o_mem_wdata = req_q.wdata;
  assign o_mem_be    = req_q.be;
  assign o_mem_bank  = req_q.bank;
  // Reset forces stall low even while an access is presented.
  assign o_StallM    = stall_c & i_RST;

endmodule

// File: tb/tb_memory_access_unit.sv
`timescale 1ns/1ps
// Self-checking bench for memory_access_unit with a lane/extension reference model.
module tb_memory_access_unit;
  localparam int TO = 16;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b0;
  logic [31:0] i_ALUOutM = '0;
  logic [31:0] i_WriteDataM = '0;
  logic        i_MemWriteM = 1'b0;
  logic [1:0]  i_MemtoRegM = 2'b00;
  logic [2:0]  i_MemDataSelM = 3'b000;
  logic [1:0]  i_RAM_selM = 2'b00;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_mem_req, o_mem_we, o_StallM, o_BusErrM;
  logic [31:0] o_mem_addr, o_mem_wdata, o_ReadDataM;
  logic [3:0]  o_mem_be;
  logic [1:0]  o_mem_bank;
`ifdef MISALIGN_TRAP_EN
  logic        o_MisalignM;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] last_rd = '0;

  memory_access_unit dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_ALUOutM(i_ALUOutM), .i_WriteDataM(i_WriteDataM),
    .i_MemWriteM(i_MemWriteM), .i_MemtoRegM(i_MemtoRegM), .i_MemDataSelM(i_MemDataSelM),
    .i_RAM_selM(i_RAM_selM), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .o_mem_bank(o_mem_bank), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_ReadDataM(o_ReadDataM), .o_StallM(o_StallM),
`ifdef MISALIGN_TRAP_EN
    .o_MisalignM(o_MisalignM),
`endif
    .o_BusErrM(o_BusErrM)
  );

  always #5 i_CLK = ~i_CLK;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] sel);
    if (sel == 3'd3 || sel == 3'd4) return 1;
    if (sel == 3'd1 || sel == 3'd2) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [2:0] sel);
    int sz = size_of(sel);
    int lo = ((addr % 4) / sz) * sz;
    return 4'(((1 << sz) - 1) << lo);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] sel);
    int sz = size_of(sel);
    if (sz == 1) return (d % 256) * 32'h0101_0101;
    if (sz == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr, input logic [2:0] sel);
    int sz = size_of(sel);
    int sh = (sz == 1) ? 8 * (addr % 4) : (sz == 2) ? 16 * ((addr / 2) % 2) : 0;
    logic [31:0] v = w >> sh;
    case (sel)
      3'd1: return (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
      3'd2: return v % 65536;
      3'd3: return (v % 256 >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
      3'd4: return v % 256;
      default: return w;
    endcase
  endfunction

  // ---------------- stimulus tasks ----------------
  // w = BUSY-cycle index on which ack is driven (0 = first); w < 0 means never ack.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] data, input logic wr, input logic rd,
                           input logic [2:0] sel, input logic [1:0] bank, input int w,
                           input logic [31:0] rdata, output logic [31:0] got_rd);
    int busy = 0;
    int bad = 0;
    logic done = 1'b0;
    int exp_busy;
    logic exp_err;
    logic [31:0] exp_rd;
    exp_err  = !(w >= 0 && w < TO);
    exp_busy = exp_err ? TO : w + 1;
    exp_rd   = (wr || exp_err) ? 32'h0 : model_load(rdata, addr, sel);
    @(posedge i_CLK); #1;
    i_ALUOutM = addr; i_WriteDataM = data; i_MemWriteM = wr;
    i_MemtoRegM = rd ? 2'b01 : ((($urandom % 2) == 0) ? 2'b00 : 2'b10);
    i_MemDataSelM = sel; i_RAM_selM = bank; i_mem_ack = 1'b0; i_mem_rdata = $urandom;
    #1;
    n_total++;
    if ({o_StallM, o_mem_req} !== 2'b10)
      $display("FAIL issue_cycle: stall/req=%b required 10", {o_StallM, o_mem_req});
    else n_pass++;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge i_CLK); #1;
      i_mem_ack = 1'b0; i_mem_rdata = $urandom;
      if (!o_StallM) done = 1'b1;
      else begin
        if (o_mem_req !== 1'b1 || o_mem_we !== wr || o_mem_addr !== {addr[31:2], 2'b00} ||
            o_mem_be !== model_be(addr, sel) || o_mem_bank !== bank ||
            (wr && o_mem_wdata !== model_wdata(data, sel))) bad++;
        if (busy == w) begin i_mem_ack = 1'b1; i_mem_rdata = rdata; end
        busy++;
      end
    end
    n_total++;
    if (done !== 1'b1) $display("FAIL done_reached: stall never released after %0d cycles", busy);
    else n_pass++;
    n_total++;
    if (busy !== exp_busy) $display("FAIL busy_cycles: got %0d required %0d (addr %h)", busy, exp_busy, addr);
    else n_pass++;
    n_total++;
    if (bad !== 0) $display("FAIL req_fields: %0d bad BUSY cycles (addr %h sel %0d we %b)", bad, addr, sel, wr);
    else n_pass++;
    n_total++;
    if ({o_mem_req, o_mem_we, o_mem_be, o_mem_addr} !== '0)
      $display("FAIL done_port_idle: req %b we %b be %b addr %h required all 0", o_mem_req, o_mem_we, o_mem_be, o_mem_addr);
    else n_pass++;
    n_total++;
    if (o_BusErrM !== exp_err) $display("FAIL bus_err: got %b required %b", o_BusErrM, exp_err);
    else n_pass++;
    n_total++;
    if (o_ReadDataM !== exp_rd) $display("FAIL read_data: got %h required %h (addr %h sel %0d)", o_ReadDataM, exp_rd, addr, sel);
    else n_pass++;
    got_rd = o_ReadDataM;
    last_rd = exp_rd;
  endtask

  task automatic idle_check(input int n, input logic stray_ack);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge i_CLK); #1;
      i_MemWriteM = 1'b0; i_MemtoRegM = (($urandom % 2) == 0) ? 2'b00 : 2'b11;
      i_ALUOutM = $urandom; i_MemDataSelM = 3'($urandom);
      i_mem_ack = stray_ack ? 1'($urandom % 2) : 1'b0; i_mem_rdata = $urandom;
      #1;
      if (o_StallM !== 1'b0 || o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_be !== 4'h0 ||
          o_mem_addr !== 32'h0 || o_BusErrM !== 1'b0 || o_ReadDataM !== last_rd) bad++;
    end
    i_mem_ack = 1'b0;
    n_total++;
    if (bad !== 0) $display("FAIL idle_quiet: %0d bad idle cycles (rd %h required hold %h)", bad, o_ReadDataM, last_rd);
    else n_pass++;
  endtask

  task automatic test_reset;
    #12;
    n_total++;
    if ({o_mem_req, o_StallM, o_BusErrM, o_mem_we} !== 4'b0000)
      $display("FAIL reset_ctrl: req/stall/err/we=%b required 0000", {o_mem_req, o_StallM, o_BusErrM, o_mem_we});
    else n_pass++;
    n_total++;
    if ({o_mem_addr, o_mem_wdata, o_mem_be, o_mem_bank} !== '0)
      $display("FAIL reset_port: addr %h wdata %h be %b bank %b required 0", o_mem_addr, o_mem_wdata, o_mem_be, o_mem_bank);
    else n_pass++;
    n_total++;
    if (o_ReadDataM !== 32'h0) $display("FAIL reset_rdata: got %h required 0", o_ReadDataM);
    else n_pass++;
    @(posedge i_CLK); #1;
    i_RST = 1'b1;
    idle_check(3, 1'b0);
  endtask

  task automatic test_directed;
    logic [31:0] got;
    do_access(32'h0000_0104, 32'h0, 1'b0, 1'b1, 3'b000, 2'b10, 0, 32'hDEAD_BEEF, got);
    n_total++;
    if (got !== 32'hDEAD_BEEF) $display("FAIL word_load: got %h required DEADBEEF", got);
    else n_pass++;
    do_access(32'h0000_0103, 32'h0, 1'b0, 1'b1, 3'b011, 2'b01, 0, 32'h8011_2233, got);
    n_total++;
    if (got !== 32'hFFFF_FF80) $display("FAIL byte_signed: got %h required FFFFFF80", got);
    else n_pass++;
    do_access(32'h0000_0103, 32'h0, 1'b0, 1'b1, 3'b100, 2'b01, 1, 32'h8011_2233, got);
    n_total++;
    if (got !== 32'h0000_0080) $display("FAIL byte_unsigned: got %h required 00000080", got);
    else n_pass++;
    do_access(32'h0000_0106, 32'h0000_ABCD, 1'b1, 1'b0, 3'b001, 2'b11, 0, 32'h1234_5678, got);
    idle_check(2, 1'b0);
  endtask

  task automatic test_timeout;
    logic [31:0] got;
    do_access(32'h0000_0200, 32'h0, 1'b0, 1'b1, 3'b000, 2'b00, -1, 32'h0, got);
    idle_check(2, 1'b0);
    do_access(32'h0000_0202, 32'h0, 1'b0, 1'b1, 3'b001, 2'b01, TO - 1, 32'h9ABC_0000, got);
    n_total++;
    if (got !== 32'hFFFF_9ABC) $display("FAIL ack_at_timeout: got %h required FFFF9ABC", got);
    else n_pass++;
    idle_check(1, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    do_access(32'h0000_0010, 32'hCAFE_F00D, 1'b1, 1'b0, 3'b000, 2'b01, 2, 32'h0, got);
    do_access(32'h0000_0012, 32'h0, 1'b0, 1'b1, 3'b010, 2'b01, 2, 32'h8765_4321, got);
    n_total++;
    if (got !== 32'h0000_8765) $display("FAIL b2b_load: got %h required 00008765", got);
    else n_pass++;
    idle_check(3, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] got;
    for (int i = 0; i < 40; i++) begin
      logic wr, rd;
      int w, r;
      wr = 1'($urandom % 2);
      rd = !wr || (($urandom % 2) == 1);
      r = $urandom_range(0, 9);
      w = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, 4);
      do_access($urandom, $urandom, wr, rd, 3'($urandom_range(0, 7)), 2'($urandom), w, $urandom, got);
      if (($urandom % 2) == 1) idle_check($urandom_range(1, 2), 1'b0);
    end
  endtask

  task automatic test_reset_mid_busy;
    @(posedge i_CLK); #1;
    i_ALUOutM = 32'h0000_0300; i_MemWriteM = 1'b1; i_MemtoRegM = 2'b01; i_WriteDataM = 32'h1111_2222;
    i_MemDataSelM = 3'b000; i_RAM_selM = 2'b11; i_mem_ack = 1'b0;
    repeat (3) @(posedge i_CLK);
    #2;
    n_total++;
    if (o_mem_req !== 1'b1) $display("FAIL pre_reset_req: got %b required 1", o_mem_req);
    else n_pass++;
    i_RST = 1'b0;
    #1;
    n_total++;
    if ({o_mem_req, o_StallM, o_BusErrM} !== 3'b000)
      $display("FAIL midreset_ctrl: req/stall/err=%b required 000", {o_mem_req, o_StallM, o_BusErrM});
    else n_pass++;
    n_total++;
    if ({o_mem_we, o_mem_be, o_mem_addr, o_mem_bank, o_mem_wdata} !== '0)
      $display("FAIL midreset_port: we %b be %b addr %h required 0", o_mem_we, o_mem_be, o_mem_addr);
    else n_pass++;
    n_total++;
    if (o_ReadDataM !== 32'h0) $display("FAIL midreset_rdata: got %h required 0", o_ReadDataM);
    else n_pass++;
    last_rd = 32'h0;
    @(posedge i_CLK); #1;
    i_MemWriteM = 1'b0; i_MemtoRegM = 2'b00;
    i_RST = 1'b1;
    idle_check(5, 1'b1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_back_to_back;
    test_random;
    test_reset_mid_busy;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- MEM-stage data-memory controller; consumes the EX/MEM pipeline register outputs and drives a synchronous data-RAM port using a req/ack handshake.
- Generates byte enables and lane-replicated write data for byte, halfword and word stores.
- Extracts and sign- or zero-extends load data.
- Holds the pipeline via o_StallM until each access completes; times out hung accesses.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 for lane logic.
- ADDRESS_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY waiting for ack; must be ≥2.

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  async active-low reset
- i_ALUOutM  in  ADDRESS_WIDTH  byte address
- i_WriteDataM  in  DATA_WIDTH  store data, right-aligned
- i_MemWriteM  in  1  store request
- i_MemtoRegM  in  2  2'b01 = load; other values mean no load
- i_MemDataSelM  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 treated as word
- i_RAM_selM  in  2  bank select, passed to o_mem_bank
- o_mem_req  out  1  request, held until ack or timeout
- o_mem_we  out  1  write strobe
- o_mem_addr  out  ADDRESS_WIDTH  word-aligned address, bits [1:0] = 0
- o_mem_wdata  out  DATA_WIDTH  lane-replicated write data
- o_mem_be  out  4  byte enables
- o_mem_bank  out  2  latched RAM_sel
- i_mem_ack  in  1  single-cycle completion
- i_mem_rdata  in  DATA_WIDTH  read word, valid with ack
- o_ReadDataM  out  DATA_WIDTH  formatted load result
- o_StallM  out  1  freeze IF..MEM stages
- o_BusErrM  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE; counter 0; all outputs 0.
- Access condition: acc = i_MemWriteM | (i_MemtoRegM == 2'b01).
- If both store and load are asserted, the access is treated as a store.
- FSM states: IDLE, BUSY, DONE.

IDLE:
- acc=1: o_StallM=1 (combinational).
- acc=1: latch we, word address, wdata, be, bank and sel/offset; next state BUSY.
- o_mem_req is registered and is 1 from the first BUSY cycle.

BUSY:
- o_StallM=1; o_mem_req=1; counter increments each cycle.
- i_mem_ack=1: register o_ReadDataM (formatted load, or 0 for a store); clear req; next state DONE.
- Counter reaches TIMEOUT_CYCLES-1 without ack: clear req; o_ReadDataM=0; pulse o_BusErrM in the DONE cycle; next state DONE.
- An ack arriving in the same cycle as the timeout wins; no error is raised.

DONE:
- o_StallM=0 for exactly one cycle so the pipeline advances.
- Next state IDLE; the new instruction is evaluated in the following cycle.
- The same instruction is never re-issued.

Latency:
- Ack on the first BUSY cycle gives 2 stall cycles, with data valid in DONE.
- Each extra wait cycle adds 1 stall cycle.

Store lanes (a = addr[1:0]):
- Byte: wdata = {4{d[7:0]}}; be = 1 << a.
- Half: wdata = {2{d[15:0]}}; be = a[1] ? 1100 : 0011.
- Word: be = 1111.

Load extraction:
- Byte lane a; half lane a[1]; extension per sel.
- Misaligned low bits are ignored: halfword uses a[1], word ignores a.

Stall and idle rules:
- o_mem_we, addr and be are stable for the whole request.
- o_mem_we, be and addr return to 0 when not in BUSY.
- o_ReadDataM holds its value until the next completion.
- Reset mid-BUSY aborts immediately: req=0, state IDLE; no ack is tracked afterwards.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled:
  - Adds output o_MisalignM (1 bit).
  - A halfword with a[0]=1, or a word with a≠0, issues no request.
  - Goes IDLE→DONE with 1 stall cycle, o_MisalignM pulsed in DONE, o_ReadDataM=0.
- Disabled:
  - Port absent; misaligned addresses are silently aligned as above.

Test Plan:
- Word load, addr 0x0000_0104, rdata 0xDEADBEEF, ack on first BUSY cycle → o_mem_addr 0x104, be 1111, stall 2 cycles, o_ReadDataM 0xDEADBEEF in DONE.
- Byte-signed load, addr 0x...03, rdata 0x80112233 → o_ReadDataM 0xFFFFFF80. Byte-unsigned, same data → 0x00000080.
- Half store, addr 0x...06, data 0x0000ABCD → we=1, be 1100, wdata 0xABCDABCD, addr 0x...04.
- No ack, TIMEOUT_CYCLES=16 → req high 16 cycles, then DONE with o_BusErrM=1 for 1 cycle, o_ReadDataM=0, stall released.
- Back-to-back store then load with ack after 3 cycles each → two separate requests; stall low for exactly one cycle between them; no duplicate request.
- Reset asserted mid-BUSY → req, stall and all outputs 0 asynchronously; after release, an idle cycle with acc=0 → no request.
